bram_port_arbiter: RTL and testbench

Parametrised N-channel arbiter and port multiplexer sharing one simple-dual-port polynomial BRAM (one write port, one read port) between the NTT, reduce and push/pop engines of the masked Kyber512 datapath. Replaces state-decoded combinational muxing:

- Channels request and are granted ownership by an arbitration FSM.
- BRAM-side ports are registered.
- Read data returns to the issuing channel through a tag pipeline matched to BRAM read latency.

---
 rtl/bram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// N-channel ownership arbiter and registered port mux for one simple-dual-port BRAM.
// Define STATE_BRAM_ARB_FIXED_PRIO_EN for fixed-priority arbitration (default round-robin).
module bram_port_arbiter #(
    parameter int NCH    = 4,
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req,
    output logic [NCH-1:0]    ch_gnt,
    input  logic [NCH-1:0]    ch_wen,
    input  logic [NCH*AW-1:0] ch_wad,
    input  logic [NCH*DW-1:0] ch_wdata,
    input  logic [NCH-1:0]    ch_ren,
    input  logic [NCH*AW-1:0] ch_rad,
    output logic [DW-1:0]     ch_rdata,
    output logic [NCH-1:0]    ch_rvalid,
    output logic              M0_WEN,
    output logic [AW-1:0]     M0_WAd,
    output logic [DW-1:0]     M0_WData,
    output logic [AW-1:0]     M0_RAd,
    input  logic [DW-1:0]     M0_RData
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [NCH-1:0]  gnt_r;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic            own_req;

    logic [RD_LAT:0] tag_vld;
    logic [IW-1:0]   tag_idx [RD_LAT+1];

`ifdef STATE_BRAM_ARB_FIXED_PRIO_EN
    function automatic logic [IW-1:0] pick_winner(input logic [NCH-1:0] req);
        logic [IW-1:0] win;
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) win = IW'(i);
        end
        return win;
    endfunction

    assign winner = pick_winner(ch_req);
`else
    logic [IW-1:0] last_owner;

    // Walk from the farthest slot back to the nearest so the first requester after last_owner wins.
    function automatic logic [IW-1:0] pick_winner(input logic [NCH-1:0] req,
                                                  input logic [IW-1:0]  last);
        logic [IW-1:0] win;
        int            c;
        win = '0;
        for (int k = NCH; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= NCH) c = c - NCH;
            if (req[c]) win = IW'(c);
        end
        return win;
    endfunction

    assign winner = pick_winner(ch_req, last_owner);
`endif

    assign own_req = (state == OWN) && ch_req[owner] && gnt_r[owner];
    assign ch_gnt  = gnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_r    <= '0;
            owner    <= '0;
`ifndef STATE_BRAM_ARB_FIXED_PRIO_EN
            last_owner <= IW'(NCH - 1);
`endif
            M0_WEN   <= 1'b0;
            M0_WAd   <= '0;
            M0_WData <= '0;
            M0_RAd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    M0_WEN <= 1'b0;
                    if (|ch_req) begin
                        owner         <= winner;
                        gnt_r         <= '0;
                        gnt_r[winner] <= 1'b1;
`ifndef STATE_BRAM_ARB_FIXED_PRIO_EN
                        last_owner    <= winner;
`endif
                        state         <= OWN;
                    end
                end
                OWN: begin
                    if (own_req) begin
                        M0_WEN   <= ch_wen[owner];
                        M0_WAd   <= ch_wad[owner*AW +: AW];
                        M0_WData <= ch_wdata[owner*DW +: DW];
                        M0_RAd   <= ch_rad[owner*AW +: AW];
                    end else begin
                        // Release cycle: the owner's strobes in this cycle are dropped.
                        M0_WEN <= 1'b0;
                        gnt_r  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read tag pipeline: stage 0 aligns with M0_RAd, stage RD_LAT with M0_RData.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i <= RD_LAT; i++) tag_idx[i] <= '0;
        end else begin
            tag_vld[0] <= own_req && ch_ren[owner];
            tag_idx[0] <= owner;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_comb begin
        ch_rvalid = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_rvalid[i] = tag_vld[RD_LAT] && (tag_idx[RD_LAT] == IW'(i));
        end
    end

    assign ch_rdata = M0_RData;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: stamped expectations from a behavioural model, checked by a monitor.
module tb_bram_port_arbiter;
    localparam int NCH = 4, AW = 8, DW = 16, RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_req, ch_gnt, ch_wen, ch_ren, ch_rvalid;
    logic [NCH*AW-1:0] ch_wad, ch_rad;
    logic [NCH*DW-1:0] ch_wdata;
    logic [DW-1:0]     ch_rdata, M0_WData, M0_RData;
    logic              M0_WEN;
    logic [AW-1:0]     M0_WAd, M0_RAd;

    bram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_gnt(ch_gnt),
        .ch_wen(ch_wen), .ch_wad(ch_wad), .ch_wdata(ch_wdata),
        .ch_ren(ch_ren), .ch_rad(ch_rad), .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid),
        .M0_WEN(M0_WEN), .M0_WAd(M0_WAd), .M0_WData(M0_WData),
        .M0_RAd(M0_RAd), .M0_RData(M0_RData)
    );

    always #5 clk = ~clk;

    // Simple BRAM with RD_LAT cycles from M0_RAd to M0_RData
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rp [RD_LAT];
    always @(posedge clk) begin
        if (M0_WEN) mem[M0_WAd] <= M0_WData;
        rp[0] <= mem[M0_RAd];
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
    assign M0_RData = rp[RD_LAT-1];

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t gnt_q[$], wr_q[$], rd_q[$];
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 0, iso_phase = 0;

    logic [DW-1:0] ref_mem [256];
    int m_owner = -1, m_last = NCH - 1, m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] r, input int last);
`ifdef STATE_BRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NCH; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NCH; k++) if (r[(last + k) % NCH]) return (last + k) % NCH;
`endif
        return -1;
    endfunction

    task automatic clear_in();
        ch_req = '0; ch_wen = '0; ch_ren = '0;
        ch_wad = '0; ch_rad = '0; ch_wdata = '0;
    endtask

    task automatic set_ch(input int i, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        ch_wen[i] = we; ch_wad[i*AW +: AW] = wa; ch_wdata[i*DW +: DW] = wd;
        ch_ren[i] = re; ch_rad[i*AW +: AW] = ra;
    endtask

    // Apply current inputs for one cycle; predict what appears on the outputs afterwards.
    task automatic tick();
        int n = cyc;
        ent_t e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (m_owner < 0) begin
            if (ch_req != '0) begin
                m_owner = pick(ch_req, m_last);
                m_last  = m_owner;
                m_cnt   = 0;
            end
        end else if (ch_req[m_owner]) begin
            m_cnt++;
            if (ch_ren[m_owner]) begin
                a = ch_rad[m_owner*AW +: AW];
                e.cyc = n + 1 + RD_LAT; e.a = 32'(1) << m_owner; e.b = 32'(ref_mem[a]);
                rd_q.push_back(e);
            end
            if (ch_wen[m_owner]) begin
                a = ch_wad[m_owner*AW +: AW];
                d = ch_wdata[m_owner*DW +: DW];
                e.cyc = n + 1; e.a = 32'(a); e.b = 32'(d);
                wr_q.push_back(e);
                ref_mem[a] = d;
            end
        end else begin
            m_owner = -1;
        end
        e.cyc = n + 1; e.a = (m_owner < 0) ? 32'd0 : (32'(1) << m_owner); e.b = '0;
        gnt_q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : monitor
        ent_t e;
        if (rst_n && mon_en) begin
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                e = gnt_q.pop_front();
                chk("grant", 32'(ch_gnt), e.a);
            end
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                e = wr_q.pop_front();
                chk("m0_wen", 32'(M0_WEN), 32'd1);
                chk("m0_wad", 32'(M0_WAd), e.a);
                chk("m0_wdata", 32'(M0_WData), e.b);
            end else begin
                chk("m0_wen_quiet", 32'(M0_WEN), 32'd0);
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                chk("rvalid", 32'(ch_rvalid), e.a);
                chk("rdata", 32'(ch_rdata), e.b);
            end else begin
                chk("rvalid_quiet", 32'(ch_rvalid), 32'd0);
            end
            if (iso_phase) chk("iso_wad", 32'(M0_WAd == 8'hFF), 32'd0);
        end
    end

    task automatic check_reset_outputs();
        chk("rst_gnt", 32'(ch_gnt), 32'd0);
        chk("rst_wen", 32'(M0_WEN), 32'd0);
        chk("rst_wad", 32'(M0_WAd), 32'd0);
        chk("rst_wdata", 32'(M0_WData), 32'd0);
        chk("rst_rad", 32'(M0_RAd), 32'd0);
        chk("rst_rvalid", 32'(ch_rvalid), 32'd0);
    endtask

    task automatic idle(input int k);
        clear_in();
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        clear_in();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1;

        // Single owner write then read-back, ending with a write in the release cycle
        clear_in(); ch_req = 4'b0010; tick();
        set_ch(1, 1, 8'h15, 16'h0ABC, 0, 8'h00); tick();
        set_ch(1, 1, 8'h40, 16'h1234, 1, 8'h15); tick();
        set_ch(1, 0, 8'h00, 16'h0000, 1, 8'h40); tick();
        ch_req = 4'b0000; set_ch(1, 1, 8'h33, 16'hDEAD, 1, 8'h33); tick();
        idle(4);

        // Round-robin with all channels requesting, owners release after 4 cycles
        for (int c = 0; c < 32; c++) begin
            clear_in();
            ch_req = 4'b1111;
            if (m_owner >= 0 && m_cnt >= 4) ch_req[m_owner] = 1'b0;
            tick();
        end
        idle(3);

        // Read in flight while ownership moves from ch0 to ch2
        clear_in(); ch_req = 4'b0001; tick();
        ch_req = 4'b0101; set_ch(0, 0, 8'h00, 16'h0000, 1, 8'h40); tick();
        clear_in(); ch_req = 4'b0100; tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            set_ch(2, 0, 8'h00, 16'h0000, 1, 8'h41 + 8'(c)); tick();
        end
        idle(5);

        // Non-owner isolation: ch3 drives strobes while ch0 owns
        iso_phase = 1;
        clear_in(); ch_req = 4'b0001; set_ch(3, 1, 8'hFF, 16'hBEEF, 1, 8'hFF); tick();
        for (int c = 0; c < 6; c++) begin
            set_ch(0, c[0], 8'h20 + 8'(c), 16'h5000 + 16'(c), ~c[0], 8'h20 + 8'(c)); tick();
        end
        ch_req = 4'b0000; tick();
        idle(5);
        iso_phase = 0;

        // Randomized traffic
        begin
            int rel = 3;
            for (int c = 0; c < 400; c++) begin
                ch_req = 4'($urandom_range(0, 15));
                for (int i = 0; i < NCH; i++)
                    set_ch(i, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom),
                           1'($urandom), 8'($urandom_range(0, 15)));
                if (m_owner >= 0) begin
                    if (m_cnt == 0) rel = $urandom_range(1, 6);
                    ch_req[m_owner] = (m_cnt < rel);
                end
                tick();
            end
        end
        idle(5);

        // Reset with two reads in flight
        clear_in(); ch_req = 4'b0001; tick();
        set_ch(0, 0, 8'h00, 16'h0000, 1, 8'h15); tick();
        set_ch(0, 0, 8'h00, 16'h0000, 1, 8'h40); tick();
        rst_n = 1'b0;
        clear_in();
        #2 check_reset_outputs();
        gnt_q.delete(); wr_q.delete(); rd_q.delete();
        m_owner = -1; m_last = NCH - 1; m_cnt = 0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            clear_in();
            ch_req = 4'b1111;
            if (m_owner >= 0 && m_cnt >= 2) ch_req[m_owner] = 1'b0;
            tick();
        end
        idle(RD_LAT + 4);
        @(negedge clk); #1;
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
